// File: rtl/instr_encoder.sv
// instr_encoder
// Byte-serial Y86-64 instruction writer. Takes one decoded instruction as
// fields over a valid/ready handshake and validates it with the same rules
// fetch uses. It then writes its 1/2/9/10-byte encoding, one byte per cycle,
// into the byte-wide instruction memory write port at an internal pointer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_addr, addr_in  reload the write pointer (IDLE only, wins over in_valid)
//   in_valid, in_ready  instruction handshake
//   icode, ifun, rA, rB instruction fields
//   valC                64-bit constant word
//   mem_we, mem_addr, mem_wdata   registered byte write port
//   done, enc_error, mem_error    completion / rejection pulses
//   len                 length of the last accepted instruction (0 if rejected)
//   next_pc             write pointer after the last instruction
module instr_encoder #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_addr,
  input  logic [63:0] addr_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        done,
  output logic        enc_error,
  output logic        mem_error,
  output logic [3:0]  len,
  output logic [63:0] next_pc
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] ptr_q, ptr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  elen_q, elen_d;
  logic [3:0]  rem_q, rem_d;
  logic [79:0] enc_q, enc_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        enc_error_q, enc_error_d;
  logic        mem_error_q, mem_error_d;

  logic        need_regids, need_valc, fields_ok, fits;
  logic [3:0]  ra_eff, rb_eff, new_len;
  logic [79:0] enc_new;

  always_comb begin
    need_regids = icode inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11};
    need_valc   = icode inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
    case (icode)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5,
      4'd8, 4'd9, 4'd10, 4'd11: fields_ok = (ifun == 4'd0);
      4'd2, 4'd7:               fields_ok = (ifun <= 4'd6);
      4'd6:                     fields_ok = (ifun <= 4'd3);
      default:                  fields_ok = 1'b0;
    endcase
    // irmovq has no source register; pushq/popq have no rB.
    ra_eff  = (icode == 4'd3) ? 4'hF : rA;
    rb_eff  = (icode == 4'd10 || icode == 4'd11) ? 4'hF : rB;
    new_len = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
    // Full encoding, byte 0 in the low bits, so emission is a right shift.
    if (need_regids) enc_new = {valC, ra_eff, rb_eff, icode, ifun};
    else             enc_new = {8'h00, valC, icode, ifun};
    // 65-bit sum so a pointer near 2^64 wrapping around is still rejected.
    fits = ({1'b0, ptr_q} + 65'(new_len)) <= 65'(MEM_BYTES);
  end

  assign in_ready = (state_q == IDLE) && !load_addr;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    elen_d      = elen_q;
    rem_d       = rem_q;
    enc_d       = enc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    enc_error_d = 1'b0;
    mem_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_addr) begin
          ptr_d = addr_in;
        end else if (in_valid) begin
          if (!fields_ok) begin
            state_d     = DONE;
            done_d      = 1'b1;
            enc_error_d = 1'b1;
            len_d       = 4'd0;
          end else if (!fits) begin
            state_d     = DONE;
            done_d      = 1'b1;
            mem_error_d = 1'b1;
            len_d       = 4'd0;
          end else begin
            // Byte 0 is registered on the acceptance edge itself.
            state_d     = EMIT;
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = enc_new[7:0];
            enc_d       = enc_new >> 8;
            rem_d       = new_len - 4'd1;
            elen_d      = new_len;
          end
        end
      end
      EMIT: begin
        if (rem_q == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          ptr_d   = ptr_q + 64'(elen_q);
          len_d   = elen_q;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + 64'd1;
          mem_wdata_d = enc_q[7:0];
          enc_d       = enc_q >> 8;
          rem_d       = rem_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 64'd0;
      len_q       <= 4'd0;
      elen_q      <= 4'd0;
      rem_q       <= 4'd0;
      enc_q       <= 80'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 8'd0;
      done_q      <= 1'b0;
      enc_error_q <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      elen_q      <= elen_d;
      rem_q       <= rem_d;
      enc_q       <= enc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      enc_error_q <= enc_error_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign enc_error = enc_error_q;
  assign mem_error = mem_error_q;
  assign len       = len_q;
  assign next_pc   = ptr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Self-checking bench for instr_encoder: directed cases followed by random
// instructions and pointer loads, compared against a reference model of the
// Y86-64 encoding rules kept in this file.
module tb_instr_encoder;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_addr = 1'b0;
  logic [63:0] addr_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [63:0] valC = '0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        done, enc_error, mem_error;
  logic [3:0]  len;
  logic [63:0] next_pc;

  int total = 0;
  int bad   = 0;
  logic [63:0] model_ptr = '0;

  instr_encoder #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .load_addr(load_addr), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .enc_error(enc_error), .mem_error(mem_error),
    .len(len), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: highest legal ifun per icode, and which icodes carry
  // a register byte / an 8-byte constant, as bit masks indexed by icode.
  function automatic bit modelValid(input int ic, input int fn);
    int max_ifun [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};
    if (ic > 11) return 0;
    return fn <= max_ifun[ic];
  endfunction

  function automatic int modelLen(input int ic);
    int has_reg, has_const;
    has_reg   = (32'h0C7C >> ic) & 1;
    has_const = (32'h01B8 >> ic) & 1;
    return 1 + has_reg + 8 * has_const;
  endfunction

  // Must be called at a negedge; leaves the bench at a negedge with in_ready high.
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [63:0] vc);
    int guard = 0;
    bit ok, fits;
    int n;
    logic [7:0] bytes [10];
    logic [3:0] ra_m, rb_m;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", 64'd0, 64'd1);
      return;
    end
    ok   = modelValid(int'(ic), int'(fn));
    n    = ok ? modelLen(int'(ic)) : 0;
    fits = ok && (model_ptr <= 64'(MEM_BYTES)) && (64'(n) <= 64'(MEM_BYTES) - model_ptr);
    ra_m = (ic == 4'd3) ? 4'hF : ra;
    rb_m = (ic == 4'd10 || ic == 4'd11) ? 4'hF : rb;
    bytes[0] = {ic, fn};
    for (int i = 0; i < 8; i++) begin
      bytes[n - 8 + i < 0 ? 0 : (n >= 9 ? n - 8 + i : 0)] = (n >= 9) ? vc[8*i +: 8] : bytes[0];
    end
    if (n == 2 || n == 10) bytes[1] = {ra_m, rb_m};
    bytes[0] = {ic, fn};

    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    icode = 4'($urandom); ifun = 4'($urandom); valC = {$urandom, $urandom};
    if (!fits) begin
      checkOutput("rej_done",      64'(done),      64'd1);
      checkOutput("rej_enc_error", 64'(enc_error), 64'(!ok));
      checkOutput("rej_mem_error", 64'(mem_error), 64'(ok));
      checkOutput("rej_no_write",  64'(mem_we),    64'd0);
      checkOutput("rej_len",       64'(len),       64'd0);
      checkOutput("rej_next_pc",   next_pc,        model_ptr);
      checkOutput("rej_ready_low", 64'(in_ready),  64'd0);
    end else begin
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        checkOutput("byte_we",    64'(mem_we),    64'd1);
        checkOutput("byte_addr",  mem_addr,       model_ptr + 64'(k));
        checkOutput("byte_data",  64'(mem_wdata), 64'(bytes[k]));
        checkOutput("byte_nodone", 64'(done),     64'd0);
      end
      @(negedge clk);
      model_ptr = model_ptr + 64'(n);
      checkOutput("done",        64'(done),      64'd1);
      checkOutput("done_enc",    64'(enc_error), 64'd0);
      checkOutput("done_mem",    64'(mem_error), 64'd0);
      checkOutput("done_no_we",  64'(mem_we),    64'd0);
      checkOutput("len",         64'(len),       64'(n));
      checkOutput("next_pc",     next_pc,        model_ptr);
      checkOutput("ready_low",   64'(in_ready),  64'd0);
    end
    @(negedge clk);
    checkOutput("ready_back",  64'(in_ready), 64'd1);
    checkOutput("done_pulse",  64'(done),     64'd0);
    checkOutput("idle_no_we",  64'(mem_we),   64'd0);
  endtask

  // Must be called at a negedge; leaves the bench at a negedge.
  task automatic loadPointer(input logic [63:0] a);
    load_addr = 1'b1;
    addr_in   = a;
    #1;
    checkOutput("ready_during_load", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    load_addr = 1'b0;
    model_ptr = a;
    checkOutput("next_pc_after_load", next_pc, a);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_we",      64'(mem_we),    64'd0);
    checkOutput("reset_done",    64'(done),      64'd0);
    checkOutput("reset_enc",     64'(enc_error), 64'd0);
    checkOutput("reset_mem",     64'(mem_error), 64'd0);
    checkOutput("reset_len",     64'(len),       64'd0);
    checkOutput("reset_next_pc", next_pc,        64'd0);
    checkOutput("reset_addr",    mem_addr,       64'd0);
    checkOutput("reset_wdata",   64'(mem_wdata), 64'd0);
    checkOutput("reset_ready",   64'(in_ready),  64'd1);

    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
    loadPointer(64'h10);
    applyStimulus(4'd3, 4'd0, 4'd5, 4'd2, 64'h0123456789ABCDEF);
    applyStimulus(4'd6, 4'd7, 4'd1, 4'd2, 64'd0);
    applyStimulus(4'd12, 4'd0, 4'd1, 4'd2, 64'd0);
    applyStimulus(4'd9, 4'd1, 4'd1, 4'd2, 64'd0);
    loadPointer(64'(MEM_BYTES - 5));
    applyStimulus(4'd8, 4'd0, 4'd0, 4'd0, 64'h100);
    loadPointer(64'(MEM_BYTES - 1));
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
    loadPointer(64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
    loadPointer(64'd0);
    applyStimulus(4'd10, 4'd0, 4'd3, 4'd0, 64'd0);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd0, 64'd0);
    checkOutput("pushq_ret_next_pc", next_pc, 64'd3);

    // load and in_valid together: the load must win, nothing is written
    load_addr = 1'b1; addr_in = 64'h200;
    in_valid = 1'b1; icode = 4'd0; ifun = 4'd0;
    #1;
    checkOutput("load_wins_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    load_addr = 1'b0; in_valid = 1'b0;
    model_ptr = 64'h200;
    checkOutput("load_wins_no_we",   64'(mem_we), 64'd0);
    checkOutput("load_wins_no_done", 64'(done),   64'd0);
    checkOutput("load_wins_next_pc", next_pc,     64'h200);

    // reset while byte 3 of a jmp is on the write port
    loadPointer(64'd0);
    icode = 4'd7; ifun = 4'd0; valC = 64'h40; in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("jmp_we",   64'(mem_we),    64'd1);
      checkOutput("jmp_addr", mem_addr,       64'(k));
      checkOutput("jmp_data", 64'(mem_wdata), (k == 0) ? 64'h70 : ((k == 1) ? 64'h40 : 64'h00));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 64'd0;
    checkOutput("abort_no_we",   64'(mem_we),   64'd0);
    checkOutput("abort_next_pc", next_pc,       64'd0);
    checkOutput("abort_ready",   64'(in_ready), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("abort_quiet", 64'(mem_we | done), 64'd0);
    end

    // random instructions and occasional pointer loads
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       loadPointer(64'd0);
          1:       loadPointer(64'($urandom_range(0, MEM_BYTES - 1)));
          default: loadPointer(64'(MEM_BYTES - $urandom_range(0, 10)));
        endcase
      end else begin
        applyStimulus(4'($urandom_range(0, 12)),
                      ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15)),
                      4'($urandom), 4'($urandom), {$urandom, $urandom});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Byte-serial instruction writer for the Y86-64 SEQ design: the write-side counterpart of the fetch stage. It accepts one decoded instruction as fields (icode, ifun, rA, rB, valC) over a valid/ready handshake and validates it with the same rules fetch applies. It then emits the instruction's 1/2/9/10-byte encoding, one byte per cycle, into the byte-wide write port of instruction memory at an internal write pointer. It is used by benches and the program loader to build images that fetch later reads back.

## Interface
- MEM_BYTES, 1024: instruction memory size in bytes; bound for mem_error.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- load_addr  in  1  in IDLE, load write pointer from addr_in.
- addr_in  in  64  new write pointer value.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept; high only in IDLE with load_addr low.
- icode, ifun, rA, rB  in  4 each  instruction fields.
- valC  in  64  constant word.
- mem_we  out  1  byte write strobe.
- mem_addr  out  64  byte address.
- mem_wdata  out  8  byte data.
- done  out  1  one-cycle pulse; instruction finished, or rejected.
- enc_error  out  1  pulse with done: invalid icode/ifun.
- mem_error  out  1  pulse with done: encoding would exceed MEM_BYTES.
- len  out  4  byte length of the last accepted instruction; 0 if it was rejected.
- next_pc  out  64  write pointer after the last instruction (valP equivalent).

## Operation
- States: IDLE, EMIT, DONE.
- Reset values: state=IDLE; pointer=0, next_pc=0; len=0; mem_we, done, enc_error, mem_error = 0; mem_addr=0, mem_wdata=0.
- IDLE:
  - load_addr=1: pointer←addr_in and next_pc←addr_in; in_ready=0 that cycle (load wins over in_valid).
  - in_valid & in_ready: latch all fields, compute the length, then check validity.
- need_regids: icode ∈ {2,3,4,5,6,10,11}.
- need_valC: icode ∈ {3,4,5,7,8}.
- len = 1 + need_regids + 8·need_valC.
- Invalid instruction when any of the following holds:
  - icode > 11;
  - ifun≠0 for icode ∈ {0,1,3,4,5,8,9,10,11};
  - ifun>6 for icode ∈ {2,7};
  - ifun>3 for icode 6.
- Invalid instruction: go to DONE with enc_error=1, len←0, no writes, pointer unchanged.
- Range check (only if valid): pointer + len > MEM_BYTES → DONE with mem_error=1, len←0, no writes. Compute in 65 bits so wrap-around counts as an error.
- Otherwise go to EMIT with byte index k=0.
- Register-field forcing: rA←0xF for icode 3; rB←0xF for icode 10 and 11. Caller values in those fields are ignored.
- Byte order in EMIT:
  - byte 0 = {icode, ifun};
  - if need_regids, next byte = {rA, rB};
  - if need_valC, valC little-endian, bits [7:0] first.
- EMIT, each cycle: mem_we=1, mem_addr=pointer+k, mem_wdata=byte k; k increments.
- After byte len-1: pointer←pointer+len, next_pc←same, go to DONE.
- DONE: done=1 for one cycle, plus enc_error/mem_error if applicable; in_ready=0; next state IDLE.
- load_addr and in_valid are ignored outside IDLE.
- rst in any state, including mid-EMIT: immediate return to reset values. Bytes already written stay in memory; no done pulse for the aborted instruction.

## Timing
- Acceptance edge E. Byte k is presented in cycle E+1+k, with all write outputs registered.
- done is high in cycle E+len+1; in_ready returns in cycle E+len+2.
- Throughput: one instruction per len+2 cycles.
- Rejected instruction (enc_error or mem_error): done/error high in cycle E+1, in_ready in cycle E+2, mem_we never asserted.
- mem_addr and mem_wdata are don't-care when mem_we=0; the bench must check them only when mem_we=1.
- next_pc and len update in the same cycle done rises, and hold until the next done or load.

## Test plan
- Reset, then in_valid with icode=0, ifun=0 → one write of 0x00 at address 0; done at E+2; len=1; next_pc=1.
- load 0x10, then irmovq (icode 3, rA=5, rB=2, valC=0x0123456789ABCDEF) → bytes 30 F2 EF CD AB 89 67 45 23 01 written at 0x10..0x19; len=10; next_pc=0x1A.
- OPq icode=6, ifun=7 → enc_error and done at E+1; no mem_we; next_pc unchanged. Repeat with icode=12 and icode=9/ifun=1 → same response.
- load MEM_BYTES-5, then call (icode 8, valC=0x100) → mem_error at E+1; no writes. load MEM_BYTES-1, then halt → one write at 1023, no error.
- Back-to-back pushq (icode 10, rA=3, rB=0) then ret (icode 9) from address 0 → A0 3F at 0..1, then 90 at 2; next_pc=3; in_ready low in each DONE cycle.
- jmp (icode 7, valC=0x40) at address 0; assert rst in the cycle byte 3 is written → no further mem_we after that cycle; state IDLE; next_pc=0; no done pulse.
